// File: rtl/regfile_read_unit_pkg.sv
// Shared definitions for the register-file read unit: datapath widths,
// the x0 index and the write-back source select encoding.
package regfile_read_unit_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);
    localparam int X0_IDX     = 0;
    localparam int CNT_W      = 2;

    // Write-back select encoding used by the WB mux that feeds wb_data.
    typedef enum logic [1:0] {
        FROM_ALU = 2'd0,
        FROM_MEM = 2'd1,
        FROM_IMM = 2'd2,
        FROM_PC  = 2'd3
    } wb_sel_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_unit_sb_counter.sv
// Per-register pending-write counter. Applies the net of one issue increment
// and up to two decrements (WB retire, EX squash) each cycle, saturating at
// both ends and flagging over/underflow on the cycle the bad update occurs.
module sb_counter #(
    parameter int CNT_W = regfile_read_unit_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_sq,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             udf
);
    import regfile_read_unit_pkg::*;

    // Two extra bits: one for the sign, one for headroom above the max count.
    localparam logic signed [CNT_W+1:0] MAX_S = $signed({2'b00, {CNT_W{1'b1}}});

    logic signed [CNT_W+1:0] sum;

    // Clamp a signed candidate count into [0, 2^CNT_W-1].
    function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [CNT_W+1:0] v);
        if (v[CNT_W+1])
            return '0;
        else if (v > MAX_S)
            return '1;
        else
            return v[CNT_W-1:0];
    endfunction

    // Net update of this cycle's events; all three may land on the same register.
    always_comb begin
        sum = $signed({2'b00, cnt})
            + $signed({{(CNT_W+1){1'b0}}, inc})
            - $signed({{(CNT_W+1){1'b0}}, dec_wb})
            - $signed({{(CNT_W+1){1'b0}}, dec_sq});
        udf = sum[CNT_W+1];
        ovf = !sum[CNT_W+1] && (sum > MAX_S);
    end

    // Counter state; reset drops every in-flight producer.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= sat_cnt(sum);
    end

endmodule

// File: rtl/regfile_read_unit.sv
// ID-stage register file: 32 x XLEN storage written by WB, two combinational
// read ports with same-cycle WB bypass, and a pending-write scoreboard that
// stalls ID while a source operand's producer is still in flight.
module regfile_read_unit #(
    parameter int XLEN  = regfile_read_unit_pkg::XLEN,
    parameter int NREG  = regfile_read_unit_pkg::NREG,
    parameter int CNT_W = regfile_read_unit_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] rs1_addr,
    input  logic [$clog2(NREG)-1:0] rs2_addr,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic                    stall,
    input  logic                    issue_valid,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    input  logic                    issue_wen,
    input  logic                    squash_valid,
    input  logic [$clog2(NREG)-1:0] squash_rd,
    input  logic                    squash_wen,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    output logic                    sb_err
);
    import regfile_read_unit_pkg::*;

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] X0 = AW'(X0_IDX);

    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] cnt  [NREG];
    logic [NREG-1:0]  ovf;
    logic [NREG-1:0]  udf;

    logic wb_hit1;
    logic wb_hit2;
    logic busy1;
    logic busy2;

    // One scoreboard counter per architectural register; x0 never pends.
    for (genvar r = 0; r < NREG; r++) begin : g_sb
        if (r == X0_IDX) begin : g_x0
            assign cnt[r] = '0;
            assign ovf[r] = 1'b0;
            assign udf[r] = 1'b0;
        end else begin : g_reg
            logic inc;
            logic dec_wb;
            logic dec_sq;
            assign inc    = issue_valid && !stall && issue_wen && (issue_rd == AW'(r));
            assign dec_wb = wb_en && (wb_addr == AW'(r));
            assign dec_sq = squash_valid && squash_wen && (squash_rd == AW'(r));
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .inc    (inc),
                .dec_wb (dec_wb),
                .dec_sq (dec_sq),
                .cnt    (cnt[r]),
                .ovf    (ovf[r]),
                .udf    (udf[r])
            );
        end
    end

    // Register storage: single WB write port, x0 writes discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_en && (wb_addr != X0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read ports: x0 reads zero, a same-cycle WB to the source wins over the array.
    always_comb begin
        wb_hit1  = wb_en && (wb_addr == rs1_addr);
        wb_hit2  = wb_en && (wb_addr == rs2_addr);
        rs1_data = '0;
        rs2_data = '0;
        if (!rst && (rs1_addr != X0))
            rs1_data = wb_hit1 ? wb_data : regs[rs1_addr];
        if (!rst && (rs2_addr != X0))
            rs2_data = wb_hit2 ? wb_data : regs[rs2_addr];
    end

    // Hazard detect: a WB retiring the last pending producer releases the
    // source this cycle, since the bypass already supplies its data.
    always_comb begin
        busy1 = (rs1_addr != X0) && (cnt[rs1_addr] > {{(CNT_W-1){1'b0}}, wb_hit1});
        busy2 = (rs2_addr != X0) && (cnt[rs2_addr] > {{(CNT_W-1){1'b0}}, wb_hit2});
        stall = !rst && ((rs1_used && busy1) || (rs2_used && busy2));
    end

    // Sticky scoreboard error: any counter that over- or underflowed.
    always_ff @(posedge clk) begin
        if (rst)
            sb_err <= 1'b0;
        else if ((|ovf) || (|udf))
            sb_err <= 1'b1;
    end

endmodule

// File: tb/tb_regfile_read_unit.sv
// Directed bench for regfile_read_unit: reset, bypass, x0, RAW stall,
// squash and scoreboard error scenarios with hand-computed expectations.
module tb_regfile_read_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used;
    logic [31:0] rs1_data, rs2_data;
    logic        stall;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_wen;
    logic        squash_valid;
    logic [4:0]  squash_rd;
    logic        squash_wen;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    regfile_read_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .stall        (stall),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_wen    (issue_wen),
        .squash_valid (squash_valid),
        .squash_rd    (squash_rd),
        .squash_wen   (squash_wen),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; inputs change and outputs are sampled #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
        issue_valid = 0; issue_rd = 0; issue_wen = 0;
        squash_valid = 0; squash_rd = 0; squash_wen = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        pulse_reset();
        // Write x1 and x2 (unissued, so sb_err also trips) then reset.
        wb_en = 1; wb_addr = 1; wb_data = 32'h1111_0001; tick();
        wb_addr = 2; wb_data = 32'h2222_0002; tick();
        idle();
        rs1_addr = 1; rs2_addr = 2; #1;
        checks++;
        if (rs1_data !== 32'h1111_0001) begin errors++; $display("FAIL pre_reset_x1: got %h want %h", rs1_data, 32'h1111_0001); end
        checks++;
        if (sb_err !== 1'b1) begin errors++; $display("FAIL pre_reset_sb_err: got %b want 1", sb_err); end
        rst = 1; #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin errors++; $display("FAIL reset_read_during: got %h/%h want 0/0", rs1_data, rs2_data); end
        tick();
        rst = 0; #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin errors++; $display("FAIL reset_read_after: got %h/%h want 0/0", rs1_data, rs2_data); end
        checks++;
        if (stall !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL reset_ctrl: stall=%b sb_err=%b want 0/0", stall, sb_err); end
    endtask

    task automatic test_bypass();
        pulse_reset();
        issue_valid = 1; issue_rd = 5; issue_wen = 1; tick();
        idle();
        rs1_addr = 5; rs1_used = 1;
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF; #1;
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_data: got %h want deadbeef", rs1_data); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL bypass_stall: got %b want 0", stall); end
        tick();
        wb_en = 0; wb_addr = 0; wb_data = 32'h0; #1;
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_array: got %h want deadbeef", rs1_data); end
        checks++;
        if (stall !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL bypass_after_ctrl: stall=%b sb_err=%b want 0/0", stall, sb_err); end
    endtask

    task automatic test_x0();
        pulse_reset();
        rs2_addr = 0; rs2_used = 1;
        wb_en = 1; wb_addr = 0; wb_data = 32'h1; #1;
        checks++;
        if (rs2_data !== 32'h0) begin errors++; $display("FAIL x0_bypass: got %h want 0", rs2_data); end
        tick();
        idle();
        issue_valid = 1; issue_rd = 0; issue_wen = 1; #1;
        checks++;
        if (rs2_data !== 32'h0) begin errors++; $display("FAIL x0_array: got %h want 0", rs2_data); end
        tick();
        idle();
        rs1_addr = 0; rs1_used = 1; rs2_addr = 0; rs2_used = 1; #1;
        checks++;
        if (stall !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL x0_ctrl: stall=%b sb_err=%b want 0/0", stall, sb_err); end
    endtask

    task automatic test_raw_stall();
        pulse_reset();
        issue_valid = 1; issue_rd = 7; issue_wen = 1; tick();
        idle();
        rs1_addr = 7; rs1_used = 1; rs2_addr = 7; rs2_used = 0;
        // Re-present an issue to x7 while stalled: must not count.
        issue_valid = 1; issue_rd = 7; issue_wen = 1; #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c1: got %b want 1", stall); end
        tick();
        issue_valid = 0; #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c2: got %b want 1", stall); end
        rs1_used = 0; #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL raw_unused_src: got %b want 0", stall); end
        rs1_used = 1;
        tick();
        wb_en = 1; wb_addr = 7; wb_data = 32'd42; #1;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'd42) begin errors++; $display("FAIL raw_wb_release: stall=%b data=%0d want 0/42", stall, rs1_data); end
        tick();
        wb_en = 0; wb_addr = 0; wb_data = 0; #1;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'd42 || sb_err !== 1'b0) begin errors++; $display("FAIL raw_after: stall=%b data=%0d sb_err=%b want 0/42/0", stall, rs1_data, sb_err); end
    endtask

    task automatic test_squash();
        pulse_reset();
        issue_valid = 1; issue_rd = 9; issue_wen = 1; tick();
        idle();
        rs2_addr = 9; rs2_used = 1;
        squash_valid = 1; squash_rd = 9; squash_wen = 1; #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL squash_same_cycle: got %b want 1", stall); end
        tick();
        squash_valid = 0; squash_rd = 0; squash_wen = 0; #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL squash_cleared: got %b want 0", stall); end
        // cnt[9] = 1, then issue + WB + squash on x9 together: 1+1-1-1 = 0.
        idle();
        issue_valid = 1; issue_rd = 9; issue_wen = 1; tick();
        idle();
        issue_valid = 1; issue_rd = 9; issue_wen = 1;
        wb_en = 1; wb_addr = 9; wb_data = 32'h0000_0909;
        squash_valid = 1; squash_rd = 9; squash_wen = 1; tick();
        idle();
        rs2_addr = 9; rs2_used = 1; #1;
        checks++;
        if (stall !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL squash_net: stall=%b sb_err=%b want 0/0", stall, sb_err); end
        checks++;
        if (rs2_data !== 32'h0000_0909) begin errors++; $display("FAIL squash_net_data: got %h want 00000909", rs2_data); end
    endtask

    task automatic test_errors();
        pulse_reset();
        wb_en = 1; wb_addr = 3; wb_data = 32'h3; tick();
        idle();
        rs1_addr = 3; rs1_used = 1; #1;
        checks++;
        if (sb_err !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL underflow: sb_err=%b stall=%b want 1/0", sb_err, stall); end
        tick(); tick();
        checks++;
        if (sb_err !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b want 1", sb_err); end

        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_rd = 4; issue_wen = 1; tick();
        end
        idle(); #1;
        checks++;
        if (sb_err !== 1'b0) begin errors++; $display("FAIL three_issues_err: got %b want 0", sb_err); end
        issue_valid = 1; issue_rd = 4; issue_wen = 1; tick();
        idle(); #1;
        checks++;
        if (sb_err !== 1'b1) begin errors++; $display("FAIL overflow: got %b want 1", sb_err); end
        // Count must have saturated at 3: third WB releases the stall.
        rs1_addr = 4; rs1_used = 1;
        wb_en = 1; wb_addr = 4; wb_data = 32'h41; #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL sat_wb1: got %b want 1", stall); end
        tick();
        wb_data = 32'h42; #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL sat_wb2: got %b want 1", stall); end
        tick();
        wb_data = 32'h43; #1;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'h43) begin errors++; $display("FAIL sat_wb3: stall=%b data=%h want 0/43", stall, rs1_data); end
        tick();
        wb_en = 0; #1;
        checks++;
        if (stall !== 1'b0 || sb_err !== 1'b1) begin errors++; $display("FAIL sat_after: stall=%b sb_err=%b want 0/1", stall, sb_err); end
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        issue_valid = 1; issue_rd = 6; issue_wen = 1; tick();
        idle();
        rs1_addr = 6; rs1_used = 1; #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b want 1", stall); end
        rst = 1; #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL midrst_during: got %b want 0", stall); end
        tick();
        rst = 0; #1;
        checks++;
        if (stall !== 1'b0 || sb_err !== 1'b0) begin errors++; $display("FAIL midrst_after: stall=%b sb_err=%b want 0/0", stall, sb_err); end
    endtask

    initial begin
        rst = 1;
        idle();
        tick();
        test_reset();
        test_bypass();
        test_x0();
        test_raw_stall();
        test_squash();
        test_errors();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
